// File: rtl/fir_out_decimator.sv
// Decimating output stage after FIR_top: keeps every OSR-th valid float sample,
// drops the first SKIP kept samples, converts to saturated fixed point and queues it.
module fir_out_decimator #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23,
    parameter int OUT_W  = 16,
    parameter int FRAC_W = 12,
    parameter int OSR    = 1,
    parameter int SKIP   = 0,
    parameter int DEPTH  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [EXP_W+MANT_W:0]     in,
    input  logic                      in_valid,
    output logic [OUT_W-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      overflow
);
    localparam int AW   = $clog2(DEPTH);
    localparam int LW   = AW + 1;
    localparam int DW   = (OSR > 1) ? $clog2(OSR) : 1;
    localparam int SW   = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam logic [OUT_W-1:0] MAXV = {1'b0, {(OUT_W-1){1'b1}}};

    logic [DW-1:0] dcnt;
    logic [SW-1:0] scnt;
    logic          keep, pass;

    assign keep = in_valid && (dcnt == '0);
    assign pass = keep && (scnt == SW'(SKIP));

    always_ff @(posedge clk) begin
        if (!rst) begin
            dcnt <= '0;
            scnt <= '0;
        end else begin
            if (in_valid)
                dcnt <= (dcnt == DW'(OSR - 1)) ? '0 : dcnt + 1'b1;
            if (keep && !pass)
                scnt <= scnt + 1'b1;
        end
    end

    // stage 1: raw float register
    logic [EXP_W+MANT_W:0] raw;
    logic                  s1_v;

    always_ff @(posedge clk) begin
        if (!rst) s1_v <= 1'b0;
        else      s1_v <= pass;
    end

    always_ff @(posedge clk) begin
        if (pass) raw <= in;
    end

    // stage 2: float -> saturated fixed point
    logic               r_s;
    logic [EXP_W-1:0]   r_e;
    logic [MANT_W-1:0]  r_m;
    logic [OUT_W-1:0]   sh_mag, mag, conv;
    int                 p;

    assign {r_s, r_e, r_m} = raw;

    // p is the output bit position of the hidden 1; p >= OUT_W-1 cannot fit
    always_comb begin
        p      = int'(r_e) - BIAS + FRAC_W;
        sh_mag = OUT_W'({1'b1, r_m, {OUT_W{1'b0}}} >> (MANT_W + OUT_W - p));
        mag    = '0;
        if (r_e == '0 || p < 0)
            mag = '0;
        else if (r_e == '1 || p >= OUT_W - 1)
            mag = MAXV;
        else
            mag = sh_mag;
        conv = r_s ? -mag : mag;
    end

    // output FIFO
    logic [AW:0]      wr_ptr, rd_ptr;
    logic [OUT_W-1:0] mem [DEPTH];
    logic             pop, full, wr;

    assign level     = wr_ptr - rd_ptr;
    assign out_valid = (level != '0);
    assign out_data  = mem[rd_ptr[AW-1:0]];
    assign pop       = out_valid && out_ready;
    assign full      = (level == LW'(DEPTH));
    assign wr        = s1_v && (!full || pop);

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr)  wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (s1_v && full && !pop) overflow <= 1'b1;
        end
    end

    // only entry 0 is cleared so out_data reads 0 straight after reset
    always_ff @(posedge clk) begin
        if (!rst)    mem[0] <= '0;
        else if (wr) mem[wr_ptr[AW-1:0]] <= conv;
    end
endmodule

// File: tb/tb_fir_out_decimator.sv
// Directed bench: instance a (OSR=1, SKIP=0, Q3.12) and instance b (OSR=4, SKIP=2, 20-bit).
module tb_fir_out_decimator;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, iv_a, rdy_a, ov_a, of_a;
    logic [31:0] in_a;
    logic [15:0] od_a;
    logic [3:0]  lvl_a;
    logic        rst_b, iv_b, rdy_b, ov_b, of_b;
    logic [31:0] in_b;
    logic [19:0] od_b;
    logic [3:0]  lvl_b;

    fir_out_decimator #(.OSR(1), .SKIP(0), .OUT_W(16), .FRAC_W(12), .DEPTH(8)) dut_a (
        .clk(clk), .rst(rst_a), .in(in_a), .in_valid(iv_a), .out_data(od_a),
        .out_valid(ov_a), .out_ready(rdy_a), .level(lvl_a), .overflow(of_a));

    fir_out_decimator #(.OSR(4), .SKIP(2), .OUT_W(20), .FRAC_W(12), .DEPTH(8)) dut_b (
        .clk(clk), .rst(rst_b), .in(in_b), .in_valid(iv_b), .out_data(od_b),
        .out_valid(ov_b), .out_ready(rdy_b), .level(lvl_b), .overflow(of_b));

    int nchk = 0, nbad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk); #1;
    endtask

    // float bits of n * 2^-sh for positive integer n
    function automatic logic [31:0] fb(input int n, input int sh);
        int e = 0;
        while ((n >> (e + 1)) != 0) e++;
        return {1'b0, 8'(127 + e - sh), 23'((n - (1 << e)) << (23 - e))};
    endfunction

    // expected Q3.12 value of integer n on instance a (saturates from 8.0)
    function automatic logic [15:0] exa(input int n);
        return (n >= 8) ? 16'h7FFF : 16'(n << 12);
    endfunction

    task automatic feed_a(input int n);
        for (int i = 1; i <= n; i++) begin
            in_a = fb(i, 0); iv_a = 1'b1; tick;
        end
        iv_a = 1'b0;
    endtask

    task automatic feed_b(input int n, input int gap);
        for (int i = 1; i <= n; i++) begin
            in_b = fb(i, 0); iv_b = 1'b1; tick;
            if (i == gap) begin
                iv_b = 1'b0;
                repeat (3) tick;
            end
        end
        iv_b = 1'b0;
    endtask

    task automatic reset_a;
        rst_a = 1'b0; tick; rst_a = 1'b1;
    endtask

    // drains instance b expecting 9.0 then 13.0
    task automatic pop_b_9_13(input string tag);
        chk({tag, "_lvl"}, 32'(lvl_b), 32'd2);
        rdy_b = 1'b1;
        chk({tag, "_d0"}, 32'(od_b), 32'h09000); tick;
        chk({tag, "_d1"}, 32'(od_b), 32'h0D000); tick;
        rdy_b = 1'b0;
        chk({tag, "_empty"}, 32'(ov_b), 32'd0);
    endtask

    // backpressure scoreboard
    logic [15:0] q[$];
    logic        mon = 1'b0, stall = 1'b0;
    logic [15:0] prev_od;

    always @(negedge clk) begin
        if (mon) begin
            if (stall) chk("stable", 32'(od_a), 32'(prev_od));
            if (ov_a && rdy_a) begin
                if (q.size() == 0) chk("sb_size", 32'(q.size()), 32'd1);
                else               chk("order", 32'(od_a), 32'(q.pop_front()));
            end
            if (lvl_a > 4'd8) chk("lvl_max", 32'(lvl_a), 32'd8);
            stall   = ov_a && !rdy_a;
            prev_od = od_a;
        end
    end

    logic [31:0] t1_in [6] = '{32'h3F800000, 32'hBF000000, 32'h42C80000,
                               32'hC2C80000, 32'h39000000, 32'h80000000};
    logic [15:0] t1_ex [6] = '{16'h1000, 16'hF800, 16'h7FFF,
                               16'h8001, 16'h0000, 16'h0000};

    initial begin
        rst_a = 1'b0; iv_a = 1'b0; rdy_a = 1'b0; in_a = '0;
        rst_b = 1'b0; iv_b = 1'b0; rdy_b = 1'b0; in_b = '0;
        repeat (2) tick;
        rst_a = 1'b1; rst_b = 1'b1;

        chk("rst_lvl", 32'(lvl_a), 32'd0);
        chk("rst_ov",  32'(ov_a),  32'd0);
        chk("rst_of",  32'(of_a),  32'd0);
        chk("rst_od",  32'(od_a),  32'd0);

        // conversion: output of sample i visible after its second edge
        rdy_a = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_a = t1_in[i]; iv_a = 1'b1; tick;
            if (i >= 1) chk($sformatf("conv%0d", i - 1), 32'(od_a), 32'(t1_ex[i-1]));
        end
        iv_a = 1'b0; tick;
        chk("conv5", 32'(od_a), 32'(t1_ex[5]));
        tick;
        chk("conv_empty", 32'(ov_a), 32'd0);

        // decimation + skip, then with a gap in in_valid
        feed_b(16, 0); repeat (2) tick;
        pop_b_9_13("dec");
        rst_b = 1'b0; tick; rst_b = 1'b1;
        feed_b(16, 6); repeat (2) tick;
        pop_b_9_13("gap");

        // full + overflow
        reset_a; rdy_a = 1'b0;
        feed_a(9); repeat (2) tick;
        chk("full_lvl", 32'(lvl_a), 32'd8);
        chk("full_of",  32'(of_a),  32'd1);
        rdy_a = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("full_pop%0d", i), 32'(od_a), 32'(exa(i))); tick;
        end
        rdy_a = 1'b0;
        chk("full_drained", 32'(ov_a), 32'd0);
        reset_a;
        chk("of_cleared", 32'(of_a), 32'd0);

        // full with simultaneous write and pop
        feed_a(8); repeat (2) tick;
        chk("fwp_lvl0", 32'(lvl_a), 32'd8);
        in_a = 32'h3F000000; iv_a = 1'b1; tick;
        iv_a = 1'b0; rdy_a = 1'b1; tick;
        rdy_a = 1'b0;
        chk("fwp_lvl", 32'(lvl_a), 32'd8);
        chk("fwp_of",  32'(of_a),  32'd0);
        rdy_a = 1'b1;
        for (int i = 2; i <= 8; i++) begin
            chk($sformatf("fwp_pop%0d", i), 32'(od_a), 32'(exa(i))); tick;
        end
        chk("fwp_last", 32'(od_a), 32'h0800); tick;
        rdy_a = 1'b0;
        chk("fwp_empty", 32'(ov_a), 32'd0);

        // random backpressure, in-order delivery and stability
        reset_a;
        mon = 1'b1;
        for (int sent = 0; sent < 1000; ) begin
            rdy_a = 1'($urandom_range(0, 1));
            if (lvl_a <= 4'd5 && $urandom_range(0, 1) == 1) begin
                sent++;
                in_a = fb(sent, 8); iv_a = 1'b1;
                q.push_back(16'(sent * 16));
            end else begin
                iv_a = 1'b0;
            end
            tick;
        end
        iv_a = 1'b0; rdy_a = 1'b1;
        repeat (20) tick;
        mon = 1'b0; rdy_a = 1'b0;
        chk("bp_drained", 32'(q.size()), 32'd0);
        chk("bp_of", 32'(of_a), 32'd0);

        // reset with level 5 and a sample in flight
        rst_b = 1'b0; tick; rst_b = 1'b1;
        feed_b(29, 0);
        chk("mid_lvl_pre", 32'(lvl_b), 32'd5);
        rst_b = 1'b0; tick; rst_b = 1'b1;
        chk("mid_lvl", 32'(lvl_b), 32'd0);
        chk("mid_ov",  32'(ov_b),  32'd0);
        chk("mid_of",  32'(of_b),  32'd0);
        chk("mid_od",  32'(od_b),  32'd0);
        tick;
        chk("mid_noflight", 32'(lvl_b), 32'd0);
        feed_b(16, 0); repeat (2) tick;
        pop_b_9_13("mid");

        $display("test done: total=%0d bad=%0d", nchk, nbad);
        $finish;
    end
endmodule

// File: doc/fir_out_decimator.md
# fir_out_decimator

Output stage directly downstream of `FIR_top`. It takes the filter's floating-point estimate stream, keeps every OSR-th valid sample, and discards a programmable number of start-up samples while the lookahead/lookback pipeline fills. Kept samples are converted to saturated signed fixed-point and buffered in a FIFO with a ready/valid output toward the downstream sink or the file writer.

## Interface
Parameters:
- `EXP_W`, default 8: exponent width of the input float.
- `MANT_W`, default 23: mantissa width of the input float, excluding the hidden bit.
- `OUT_W`, default 16: output fixed-point width, two's complement.
- `FRAC_W`, default 12: fractional bits of the output.
- `OSR`, default 1: decimation factor, ≥1.
- `SKIP`, default 0: number of kept samples discarded after reset.
- `DEPTH`, default 8: FIFO depth, power of 2, ≥2.

Ports:
- `clk` in 1: clock. Reset is synchronous and active-low.
- `rst` in 1: reset, synchronous, active-low.
- `in` in 1+EXP_W+MANT_W: float sample, packed as {sign, exponent, mantissa}.
- `in_valid` in 1: `in` is valid this cycle.
- `out_data` out OUT_W: head of FIFO.
- `out_valid` out 1: FIFO not empty.
- `out_ready` in 1: sink accepts `out_data`.
- `level` out $clog2(DEPTH)+1: FIFO occupancy.
- `overflow` out 1: sticky flag, set when a kept sample is dropped because the FIFO is full.

## Operation
- **Decimation counter** `dcnt`, range 0..OSR-1:
  - Advances only on `in_valid`; wraps OSR-1→0.
  - A sample is "kept" when `in_valid`=1 and `dcnt`=0.
  - With OSR=1, every valid sample is kept.
- **Skip counter:**
  - Counts kept samples up to SKIP, then saturates.
  - While count < SKIP, kept samples are dropped. They do not count toward overflow.
- **Stage 1:** a kept, non-skipped sample is registered into the raw register, with valid bit `s1_v`.
- **Stage 2:** converts the raw value and writes the FIFO.
- **Conversion:** bias = 2^(EXP_W-1)-1; value = (-1)^s · 1.m · 2^(e-bias).
  - e=0 gives 0 (denormals flush to zero, sign ignored).
  - e = all-ones saturates by sign.
  - Magnitude is scaled by 2^FRAC_W and truncated toward zero.
  - If magnitude > 2^(OUT_W-1)-1, it clamps to 2^(OUT_W-1)-1, negated if sign=1. The range is symmetric; -2^(OUT_W-1) is never produced.
  - Negative results are the two's complement of the truncated magnitude.
- **FIFO:** circular buffer with write/read pointers one bit wider than the address.
  - `out_valid` = (`level`≠0); `out_data` = mem[rd_ptr].
  - Pop happens when `out_valid` and `out_ready`.
  - Write is accepted when `level`<DEPTH, or when a pop occurs the same cycle (full + pop + write: `level` stays DEPTH).
  - Write while full with no pop: the sample is dropped and `overflow` is set.
  - Pointers wrap modulo 2·DEPTH; address = pointer mod DEPTH.
- **`overflow`:** cleared only by reset.

## Timing
- **Reset** (`rst`=0 at a rising edge):
  - `dcnt`=0, skip count=0, `s1_v`=0, pointers=0.
  - Outputs: `level`=0, `out_valid`=0, `overflow`=0, `out_data`=0 (memory entry 0 cleared).
  - Reset asserted mid-operation discards all buffered and in-flight samples in that same cycle.
- **First post-reset sample:** the first `in_valid` sample after reset release is kept (`dcnt`=0).
- **Latency:**
  - A kept sample is sampled at edge k and written to the FIFO at edge k+1.
  - If the FIFO was empty, `out_valid`=1 after edge k+1. There is no same-cycle fall-through.
- **Throughput:** one write and one pop per cycle.
  - `level` is unchanged on simultaneous write and pop.
  - `level` +1 on write only; -1 on pop only.
- **Output stability:** `out_data` holds stable while `out_valid`=1 and `out_ready`=0.
- **Overflow timing:** `overflow` rises the cycle after the dropped write edge.
- **`in_valid` gaps:** gaps freeze `dcnt`. Decimation counts valid samples, not cycles.

## Test plan
1. **Conversion** (EXP_W=8, MANT_W=23, OUT_W=16, FRAC_W=12, OSR=1, SKIP=0), `in_valid`=1, `out_ready`=1. Inputs and required outputs, each 2 edges later:
   - 0x3F800000 → 0x1000
   - 0xBF000000 → 0xF800
   - 0x42C80000 → 0x7FFF
   - 0xC2C80000 → 0x8001
   - 0x39000000 → 0x0000
   - 0x80000000 → 0x0000
2. **Decimation and skip** (OSR=4, SKIP=2): continuous `in_valid` with inputs 1.0, 2.0, …, 16.0.
   - Output sequence is 9.0, 13.0 (0x9000, 0xD000).
   - A 3-cycle `in_valid` gap does not shift the selection phase.
3. **Full/overflow** (DEPTH=8), `out_ready`=0, 9 kept samples 1.0..9.0:
   - `level`=8 and `overflow`=1.
   - Then with `out_ready`=1, pops yield 1.0..8.0; 9.0 never appears.
4. **Full + simultaneous write/pop:**
   - With `level`=8, assert `out_ready` and a kept sample in the same cycle.
   - `level` stays 8, `overflow` stays 0, and the new sample appears last.
5. **Backpressure and wrap:** random `out_ready` (50%) over 1000 samples.
   - Output order equals input order.
   - `out_data` is stable while stalled; `level` never exceeds 8.
6. **Reset mid-operation:** apply `rst`=0 for 1 cycle with `level`=5 and `s1_v`=1.
   - After that edge: `level`=0, `out_valid`=0, `overflow`=0.
   - The next `in_valid` sample is kept and is subject to SKIP again.
